// File: rtl/hotspot_stencil_pkg.sv
// hotspot_stencil_pkg
//   Shared definitions for the hotspot stencil window generator:
//   default word width, word offsets of the packed {c,n,s,e,w} tuple,
//   and the frame-sequencing state encoding.
package hotspot_stencil_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Word offsets inside the 5-word output tuple (c in the MSBs)
    localparam int unsigned C_OFF = 4;
    localparam int unsigned N_OFF = 3;
    localparam int unsigned S_OFF = 2;
    localparam int unsigned E_OFF = 1;
    localparam int unsigned W_OFF = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/hotspot_stencil_window_gen_line_buffer.sv
// hotspot_line_buffer
//   Two MAX_COLS-deep rows of temperature words: cur[] (row r) and
//   prev[] (row r-1). Contents are not reset.
// Ports:
//   i_clk        clock
//   i_col        column for both the reads and the shift-write
//   i_we         shift-write enable: prev[col] <= cur[col]; cur[col] <= i_din
//   i_din        word written into cur[col]
//   o_cur_c      cur[col]
//   o_cur_next   cur[col+1] (cur[col] at the last physical column)
//   o_prev_c     prev[col]
module hotspot_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_COLS   = 64,
    parameter int unsigned COL_W      = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
    input  logic                  i_clk,
    input  logic [COL_W-1:0]      i_col,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_cur_c,
    output logic [DATA_WIDTH-1:0] o_cur_next,
    output logic [DATA_WIDTH-1:0] o_prev_c
);

    logic [DATA_WIDTH-1:0] r_cur  [MAX_COLS];
    logic [DATA_WIDTH-1:0] r_prev [MAX_COLS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_prev[i_col] <= r_cur[i_col];
            r_cur[i_col]  <= i_din;
        end
    end

    always_comb begin
        o_cur_c    = r_cur[i_col];
        o_prev_c   = r_prev[i_col];
        o_cur_next = r_cur[i_col];
        if (i_col != COL_W'(MAX_COLS - 1)) begin
            o_cur_next = r_cur[i_col + COL_W'(1)];
        end
    end

endmodule

// File: rtl/hotspot_stencil_window_gen.sv
// hotspot_stencil_window_gen
//   Turns a raster stream of Q10.22 temperature cells into one packed
//   {c,n,s,e,w} tuple per cell, same raster order, grid edges clamped
//   to the centre value. Row 0 is buffered first; every later input
//   cell releases the tuple of the cell directly above it; the last row
//   is flushed out of the line buffer after the input ends.
// Ports:
//   aclk, axi_reset               clock, async active-high reset
//   start, num_rows, num_cols     frame start pulse and grid size
//   s_axis_temp_*                 cell input stream
//   m_axis_stencil_*              tuple output stream (registered)
//   busy, done                    frame in progress / end-of-frame pulse
// Build option:
//   HOTSPOT_STENCIL_TLAST_EN adds m_axis_stencil_last, high on the
//   tuple of the final cell.
module hotspot_stencil_window_gen
    import hotspot_stencil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_COLS   = 64,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    axi_reset,
    input  logic                    start,
    input  logic [DIM_WIDTH-1:0]    num_rows,
    input  logic [DIM_WIDTH-1:0]    num_cols,
    input  logic [DATA_WIDTH-1:0]   s_axis_temp_data,
    input  logic                    s_axis_temp_valid,
    output logic                    s_axis_temp_ready,
    output logic [DATA_WIDTH*5-1:0] m_axis_stencil_data,
    output logic                    m_axis_stencil_valid,
    input  logic                    m_axis_stencil_ready,
`ifdef HOTSPOT_STENCIL_TLAST_EN
    output logic                    m_axis_stencil_last,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned COL_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    state_t r_state, w_state_next;

    logic [DIM_WIDTH-1:0]    r_rows, r_cols;
    logic [DIM_WIDTH-1:0]    r_row, r_col;   // input row / shared column
    logic                    r_flushed;      // last flush tuple already issued
    logic [DATA_WIDTH-1:0]   r_w;
    logic [DATA_WIDTH*5-1:0] r_data;
    logic                    r_valid;
    logic                    r_last;

    logic                    w_start_ok;
    logic                    w_in_fire;
    logic                    w_out_free;
    logic                    w_stream_fire;
    logic                    w_flush_emit;
    logic                    w_emit;
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_top_row;
    logic [DATA_WIDTH-1:0]   w_cur_c, w_cur_next, w_prev_c;
    logic [DATA_WIDTH-1:0]   w_n, w_s, w_e, w_w;
    logic [DATA_WIDTH*5-1:0] w_tuple;

    hotspot_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_COLS   (MAX_COLS),
        .COL_W      (COL_W)
    ) u_line_buffer (
        .i_clk      (aclk),
        .i_col      (r_col[COL_W-1:0]),
        .i_we       (w_in_fire),
        .i_din      (s_axis_temp_data),
        .o_cur_c    (w_cur_c),
        .o_cur_next (w_cur_next),
        .o_prev_c   (w_prev_c)
    );

    assign w_start_ok = (r_state == ST_IDLE) && start &&
                        (num_rows != '0) && (num_cols != '0) &&
                        (num_cols <= DIM_WIDTH'(MAX_COLS));
    assign w_in_fire     = s_axis_temp_valid && s_axis_temp_ready;
    assign w_out_free    = !r_valid || m_axis_stencil_ready;
    assign w_stream_fire = (r_state == ST_STREAM) && w_in_fire;
    assign w_flush_emit  = (r_state == ST_FLUSH) && !r_flushed && w_out_free;
    assign w_emit        = w_stream_fire || w_flush_emit;
    assign w_last_col    = (r_col == r_cols - DIM_WIDTH'(1));
    assign w_last_row    = (r_row == r_rows - DIM_WIDTH'(1));
    // While streaming, the tuple being emitted belongs to row r_row-1;
    // during flush it belongs to the last row.
    assign w_top_row     = (r_state == ST_FLUSH) ? (r_rows == DIM_WIDTH'(1))
                                                 : (r_row  == DIM_WIDTH'(1));

    always_comb begin
        w_n = w_top_row  ? w_cur_c : w_prev_c;
        w_e = w_last_col ? w_cur_c : w_cur_next;
        w_w = (r_col == '0) ? w_cur_c : r_w;
        w_s = (r_state == ST_FLUSH) ? w_cur_c : s_axis_temp_data;
        w_tuple = '0;
        w_tuple[C_OFF*DATA_WIDTH +: DATA_WIDTH] = w_cur_c;
        w_tuple[N_OFF*DATA_WIDTH +: DATA_WIDTH] = w_n;
        w_tuple[S_OFF*DATA_WIDTH +: DATA_WIDTH] = w_s;
        w_tuple[E_OFF*DATA_WIDTH +: DATA_WIDTH] = w_e;
        w_tuple[W_OFF*DATA_WIDTH +: DATA_WIDTH] = w_w;
    end

    always_ff @(posedge aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        s_axis_temp_ready = 1'b0;
        busy              = (r_state != ST_IDLE);
        done              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                s_axis_temp_ready = 1'b1;
                if (w_in_fire && w_last_col) begin
                    w_state_next = (r_rows == DIM_WIDTH'(1)) ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                s_axis_temp_ready = w_out_free;
                if (w_in_fire && w_last_col && w_last_row) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flushed && w_out_free) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_rows    <= '0;
            r_cols    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_flushed <= 1'b0;
            r_w       <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_rows    <= num_rows;
                r_cols    <= num_cols;
                r_row     <= '0;
                r_col     <= '0;
                r_flushed <= 1'b0;
            end

            if (w_in_fire) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_WIDTH'(1);
                end else begin
                    r_col <= r_col + DIM_WIDTH'(1);
                end
            end

            if (w_flush_emit) begin
                if (w_last_col) r_flushed <= 1'b1;
                else            r_col     <= r_col + DIM_WIDTH'(1);
            end

            if (w_emit) begin
                r_w     <= w_cur_c;   // becomes w for the next column
                r_data  <= w_tuple;
                r_valid <= 1'b1;
                r_last  <= (r_state == ST_FLUSH) && w_last_col;
            end else if (m_axis_stencil_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign m_axis_stencil_data  = r_data;
    assign m_axis_stencil_valid = r_valid;

`ifdef HOTSPOT_STENCIL_TLAST_EN
    assign m_axis_stencil_last = r_last;
`else
    logic w_last_unused;
    assign w_last_unused = r_last;
`endif

endmodule

// File: tb/tb_hotspot_stencil_window_gen.sv
module tb_hotspot_stencil_window_gen;

    logic         aclk = 1'b0;
    logic         axi_reset;
    logic         start;
    logic [15:0]  num_rows, num_cols;
    logic [31:0]  s_data;
    logic         s_valid, s_ready;
    logic [159:0] m_data;
    logic         m_valid, m_ready;
    logic         busy, done;
`ifdef HOTSPOT_STENCIL_TLAST_EN
    logic         m_last;
`endif

    always #5 aclk = ~aclk;

    hotspot_stencil_window_gen #(
        .DATA_WIDTH (32),
        .MAX_COLS   (64),
        .DIM_WIDTH  (16)
    ) dut (
        .aclk                 (aclk),
        .axi_reset            (axi_reset),
        .start                (start),
        .num_rows             (num_rows),
        .num_cols             (num_cols),
        .s_axis_temp_data     (s_data),
        .s_axis_temp_valid    (s_valid),
        .s_axis_temp_ready    (s_ready),
        .m_axis_stencil_data  (m_data),
        .m_axis_stencil_valid (m_valid),
        .m_axis_stencil_ready (m_ready),
`ifdef HOTSPOT_STENCIL_TLAST_EN
        .m_axis_stencil_last  (m_last),
`endif
        .busy                 (busy),
        .done                 (done)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]  grid [0:63];
    logic [159:0] got  [0:63];
    bit           got_last [0:63];
    int           out_cnt, done_cnt, stall_err, ready_err;
    bit           timed_out, busy_after;
    logic [3:0]   pat = 4'b1001;   // ready pattern 1,0,0,1 (bit0 first)

    function automatic logic [31:0] q(input int v);
        return 32'(v) << 22;
    endfunction

    function automatic logic [159:0] pack5(input int c, input int n, input int s,
                                           input int e, input int w);
        return {q(c), q(n), q(s), q(e), q(w)};
    endfunction

    // Reference: neighbours taken straight from the grid, clamped at edges.
    function automatic logic [159:0] model(input int rows, input int cols,
                                           input int r, input int c);
        logic [31:0] vc, vn, vs, ve, vw;
        vc = grid[r*cols + c];
        vn = (r == 0)        ? vc : grid[(r-1)*cols + c];
        vs = (r == rows - 1) ? vc : grid[(r+1)*cols + c];
        ve = (c == cols - 1) ? vc : grid[r*cols + c + 1];
        vw = (c == 0)        ? vc : grid[r*cols + c - 1];
        return {vc, vn, vs, ve, vw};
    endfunction

    task automatic run_frame(input int rows, input int cols, input bit toggle);
        int in_idx, cyc, total;
        bit prev_stall, saw_done;
        logic [159:0] prev_data;
        total = rows * cols;
        out_cnt = 0; done_cnt = 0; stall_err = 0; ready_err = 0;
        for (int i = 0; i < 64; i++) begin got[i] = '0; got_last[i] = 1'b0; end
        @(negedge aclk);
        num_rows = 16'(rows); num_cols = 16'(cols); start = 1'b1; m_ready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        in_idx = 0; cyc = 0; saw_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
        while (!saw_done && cyc < 2000) begin
            m_ready = toggle ? pat[cyc % 4] : 1'b1;
            s_valid = (in_idx < total);
            s_data  = s_valid ? grid[in_idx] : '0;
            #1;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
            if (m_valid && !m_ready && s_ready) ready_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                if (out_cnt < 64) begin
                    got[out_cnt] = m_data;
`ifdef HOTSPOT_STENCIL_TLAST_EN
                    got_last[out_cnt] = m_last;
`endif
                end
                out_cnt++;
            end
            if (s_valid && s_ready) in_idx++;
            if (done) begin done_cnt++; saw_done = 1'b1; end
            cyc++;
            @(negedge aclk);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        timed_out = !saw_done;
        #1 busy_after = busy;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            #1 if (done) done_cnt++;
        end
    endtask

    task automatic test_reset;
        axi_reset = 1'b1; start = 1'b0; num_rows = '0; num_cols = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        #3;
        checks++;
        if ({m_valid, s_ready, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got {valid,ready,busy,done}=%b required 0000",
                     {m_valid, s_ready, busy, done});
        end
        checks++;
        if (m_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", m_data);
        end
        @(negedge aclk); @(negedge aclk);
        axi_reset = 1'b0;
        #1;
        checks++;
        if ({m_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got {valid,busy}=%b required 00", {m_valid, busy});
        end
    endtask

    task automatic test_grid_3x3;
        int exp3 [0:44] = '{1,1,4,2,1,  2,2,5,3,1,  3,3,6,3,2,
                            4,1,7,5,4,  5,2,8,6,4,  6,3,9,6,5,
                            7,4,7,8,7,  8,5,8,9,7,  9,6,9,9,8};
        logic [159:0] e;
        for (int i = 0; i < 9; i++) grid[i] = q(i + 1);
        run_frame(3, 3, 1'b0);
        checks++;
        if (timed_out || out_cnt != 9) begin
            errors++;
            $display("FAIL g3x3_count: got %0d tuples (timeout=%0d) required 9", out_cnt, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            e = pack5(exp3[i*5], exp3[i*5+1], exp3[i*5+2], exp3[i*5+3], exp3[i*5+4]);
            checks++;
            if (got[i] !== e) begin
                errors++;
                $display("FAIL g3x3_tuple%0d: got %h required %h", i, got[i], e);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL g3x3_done: got %0d done pulses required 1", done_cnt);
        end
    endtask

    task automatic test_single_cell;
        grid[0] = q(7);
        run_frame(1, 1, 1'b0);
        checks++;
        if (timed_out || out_cnt != 1) begin
            errors++;
            $display("FAIL g1x1_count: got %0d tuples (timeout=%0d) required 1", out_cnt, timed_out);
        end
        checks++;
        if (got[0] !== pack5(7, 7, 7, 7, 7)) begin
            errors++;
            $display("FAIL g1x1_tuple: got %h required %h", got[0], pack5(7, 7, 7, 7, 7));
        end
        checks++;
        if (busy_after !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL g1x1_busy_done: got busy_after=%0d done=%0d required 0 and 1",
                     busy_after, done_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [159:0] e;
        for (int i = 0; i < 8; i++) grid[i] = q(10 + i);
        run_frame(2, 4, 1'b1);
        checks++;
        if (timed_out || out_cnt != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d tuples (timeout=%0d) required 8", out_cnt, timed_out);
        end
        for (int i = 0; i < 8; i++) begin
            e = model(2, 4, i / 4, i % 4);
            checks++;
            if (got[i] !== e) begin
                errors++;
                $display("FAIL bp_tuple%0d: got %h required %h", i, got[i], e);
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stalled cycles required 0", stall_err);
        end
        checks++;
        if (ready_err != 0) begin
            errors++;
            $display("FAIL bp_in_ready: got %0d stalled cycles with input ready required 0", ready_err);
        end
    endtask

    task automatic test_bad_start;
        int bad [0:1] = '{0, 65};
        for (int b = 0; b < 2; b++) begin
            @(negedge aclk);
            num_rows = 16'd3; num_cols = 16'(bad[b]); start = 1'b1;
            s_valid = 1'b1; s_data = q(99);
            @(negedge aclk);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #1;
                checks++;
                if (busy !== 1'b0 || s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bad_start_cols%0d: got busy=%0d ready=%0d required 0 0",
                             bad[b], busy, s_ready);
                end
                @(negedge aclk);
            end
            s_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midframe;
        int in_idx, cyc;
        logic [159:0] e;
        for (int i = 0; i < 16; i++) grid[i] = q(100 + i);
        @(negedge aclk);
        num_rows = 16'd4; num_cols = 16'd4; start = 1'b1; m_ready = 1'b1;
        @(negedge aclk);
        start = 1'b0; in_idx = 0; cyc = 0;
        while (in_idx < 9 && cyc < 100) begin
            s_valid = 1'b1; s_data = grid[in_idx];
            #1 if (s_valid && s_ready) in_idx++;
            cyc++;
            @(negedge aclk);
        end
        s_valid = 1'b0;
        #2 axi_reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got valid=%0d busy=%0d required 0 0", m_valid, busy);
        end
        @(negedge aclk); @(negedge aclk);
        axi_reset = 1'b0;
        for (int i = 0; i < 4; i++) grid[i] = q(21 + i);
        run_frame(2, 2, 1'b0);
        checks++;
        if (timed_out || out_cnt != 4) begin
            errors++;
            $display("FAIL midreset_count: got %0d tuples (timeout=%0d) required 4", out_cnt, timed_out);
        end
        checks++;
        if (got[0] !== pack5(21, 21, 23, 22, 21)) begin
            errors++;
            $display("FAIL midreset_first: got %h required %h", got[0], pack5(21, 21, 23, 22, 21));
        end
        for (int i = 1; i < 4; i++) begin
            e = model(2, 2, i / 2, i % 2);
            checks++;
            if (got[i] !== e) begin
                errors++;
                $display("FAIL midreset_tuple%0d: got %h required %h", i, got[i], e);
            end
        end
    endtask

`ifdef HOTSPOT_STENCIL_TLAST_EN
    task automatic test_tlast;
        for (int i = 0; i < 6; i++) grid[i] = q(40 + i);
        run_frame(3, 2, 1'b0);
        checks++;
        if (timed_out || out_cnt != 6) begin
            errors++;
            $display("FAIL tlast_count: got %0d tuples required 6", out_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL tlast_flag%0d: got %0d required %0d", i, got_last[i], (i == 5));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_grid_3x3();
        test_single_cell();
        test_backpressure();
        test_bad_start();
        test_reset_midframe();
`ifdef HOTSPOT_STENCIL_TLAST_EN
        test_tlast();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hotspot_stencil_window_gen.md
Name: hotspot_stencil_window_gen

Overview:
- Producer side of the hotspot kernel's 160-bit temperature interface.
- Accepts a raster-order stream of single Q10.22 temperature cells and emits one packed {c,n,s,e,w} tuple per cell, in the same raster order.
- Grid-edge neighbours are clamped to the centre value.
- Sits between the DMA read path and the kernel's temperature buffer, replacing CPU-side neighbour packing.

Parameters:
- DATA_WIDTH, 32, width of one temperature word (Q10.22).
- MAX_COLS, 64, maximum grid width; sets line-buffer depth.
- DIM_WIDTH, 16, width of the runtime row/column count inputs.

Ports:
- aclk  in  1  clock.
- axi_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches num_rows/num_cols and begins a frame.
- num_rows  in  DIM_WIDTH  grid height, 1..2^DIM_WIDTH-1.
- num_cols  in  DIM_WIDTH  grid width, 1..MAX_COLS.
- s_axis_temp_data  in  DATA_WIDTH  raster cell input.
- s_axis_temp_valid  in  1  input valid.
- s_axis_temp_ready  out  1  input ready.
- m_axis_stencil_data  out  DATA_WIDTH*5  packed [c,n,s,e,w]; c in the MSBs, w in the LSBs.
- m_axis_stencil_valid  out  1  output valid.
- m_axis_stencil_ready  in  1  output ready.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last tuple is accepted downstream.

Behaviour:
- Reset values (asynchronous, axi_reset=1): state IDLE; all outputs 0; line buffers not cleared.
- Transfers occur only on valid&ready, on both interfaces. Output data is registered and held stable while valid=1 and ready=0.
- s_axis_temp_ready = (state is FILL) or (state is STREAM and (~m_axis_stencil_valid or m_axis_stencil_ready)). It is 0 in IDLE, FLUSH and DONE.
- Internal storage:
  - cur[] holds row r; prev[] holds row r-1.
  - w_reg holds cur[c-1] from before the overwrite.
  - Counters: in_row, in_col for input position; out_row, out_col for output position.
- IDLE:
  - A start is accepted only if 1<=num_cols<=MAX_COLS and num_rows>=1. Otherwise it is ignored and the block stays IDLE.
  - On accept: latch config, clear counters, go to FILL.
- FILL (row 0):
  - Each accepted cell is written to cur[in_col]; no output is produced.
  - At the end of the row: if num_rows==1 go to FLUSH, else go to STREAM.
- STREAM:
  - Accepting input (r+1, c) emits the tuple for cell (r, c) in the same cycle's register update:
    - c = cur[c]
    - s = input
    - n = prev[c], or c when r==0
    - e = cur[c+1], or c when c==num_cols-1
    - w = w_reg, or c when c==0
  - Buffer updates on the same accept: prev[c] <= cur[c]; cur[c] <= input.
  - After the last input cell is accepted, go to FLUSH.
- FLUSH:
  - Emits the final row (num_rows-1) from cur/prev with s=c, one tuple per output handshake slot.
  - Same n/e/w clamps as STREAM.
  - After the last tuple is accepted, go to DONE.
- DONE: drive done=1 for one cycle, then go to IDLE.
- busy = (state != IDLE).
- Latency: first tuple valid 1 cycle after input (1,0) is accepted; no bubbles under continuous valid/ready.
- Single-cell grid (1x1): exactly one tuple, all five fields equal.
- start received while busy: ignored.
- Asynchronous reset mid-frame: immediately returns to IDLE, m_axis_stencil_valid=0, partial frame discarded.

Optional Feature:
- HOTSPOT_STENCIL_TLAST_EN defined: adds output port m_axis_stencil_last (1 bit), asserted together with valid on the tuple for cell (num_rows-1, num_cols-1), reset value 0.
- Undefined: the port does not exist, and frame end is signalled only by done.

Decomposition:
- Package hotspot_stencil_pkg contains:
  - DATA_WIDTH default.
  - Field offset constants: C_OFF=4, N_OFF=3, S_OFF=2, E_OFF=1, W_OFF=0 (in words).
  - State enum: IDLE, FILL, STREAM, FLUSH, DONE.
- Sub-module hotspot_line_buffer: two MAX_COLS-deep register rows (cur/prev). It provides a combinational read of cur[c], cur[c+1] and prev[c], and a shift-write (prev<=cur, cur<=din) at one column.

Test Plan:
- 3x3 grid, values 1..9 (Q10.22 integers), ready=1 throughout -> 9 tuples in raster order. Centre cell 5 gives {5,2,8,6,4}; corner cell 1 gives {1,1,4,2,1}; cell 9 gives {9,6,9,9,8}; done pulses once.
- 1x1 grid, value 7 -> single tuple {7,7,7,7,7}; busy drops the cycle after done.
- 2x4 grid with m_axis_stencil_ready toggling 1,0,0,1 -> output data held stable while stalled, input ready=0 during stalls, all 8 tuples correct with no loss or duplication.
- start with num_cols=0, and separately with num_cols=MAX_COLS+1 -> start ignored, busy stays 0, no input accepted.
- axi_reset asserted during row 2 of a 4x4 frame, then a new 2x2 frame started -> the new frame's outputs are correct, with no stale tuples from the aborted frame.
- With HOTSPOT_STENCIL_TLAST_EN defined, 3x2 grid -> m_axis_stencil_last=1 only on the 6th tuple.
